// File: rtl/alu_pkg.sv
// Shared definitions for the sequential ALU: opcodes, FSM states and the
// immediate sign-extension helper.
package alu_pkg;

    typedef enum logic [2:0] {
        OP_ADD  = 3'b000,
        OP_AND  = 3'b001,
        OP_NAND = 3'b010,
        OP_NOR  = 3'b011,
        OP_SUB  = 3'b100,
        OP_SHL  = 3'b101,
        OP_SHR  = 3'b110,
        OP_MUL  = 3'b111
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_DONE = 2'd2
    } state_e;

    // Sign-extends the low 'bits' bits of val to 64 bits; callers truncate.
    function automatic logic [63:0] sign_extend(input logic [63:0] val,
                                                input int unsigned bits);
        logic [63:0] hi_mask;
        logic        sign_bit;
        hi_mask  = ~64'd0 << bits;
        sign_bit = |(val & (64'd1 << (bits - 1)));
        return sign_bit ? (val | hi_mask) : (val & ~hi_mask);
    endfunction

endpackage

// File: rtl/alu_comb_core.sv
// Single-cycle ALU operations (ADD/SUB/AND/NAND/NOR) and their status flags.
module alu_comb_core
    import alu_pkg::*;
#(
    parameter int WIDTH = 18
) (
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] result,
    output logic             flag_z,
    output logic             flag_n,
    output logic             flag_c,
    output logic             flag_v
);

    logic             w_sub;
    logic [WIDTH-1:0] w_b_eff;
    logic [WIDTH:0]   w_sum;

    always_comb begin
        w_sub   = (op == OP_SUB);
        // SUB reuses the adder as A + ~B + 1, so carry-out means "no borrow".
        w_b_eff = w_sub ? ~b : b;
        w_sum   = {1'b0, a} + {1'b0, w_b_eff} + {{WIDTH{1'b0}}, w_sub};

        result = '0;
        flag_c = 1'b0;
        flag_v = 1'b0;
        case (op)
            OP_ADD, OP_SUB: begin
                result = w_sum[WIDTH-1:0];
                flag_c = w_sum[WIDTH];
                flag_v = (a[WIDTH-1] == w_b_eff[WIDTH-1]) &&
                         (w_sum[WIDTH-1] != a[WIDTH-1]);
            end
            OP_AND:  result = a & b;
            OP_NAND: result = ~(a & b);
            OP_NOR:  result = ~(a | b);
            default: result = '0;
        endcase

        flag_z = (result == '0);
        flag_n = result[WIDTH-1];
    end

endmodule

// File: rtl/alu_seq.sv
// Handshaked ALU: single-cycle ops via alu_comb_core, bit-serial shifts and
// shift-add multiply sequenced here; result and flags are registered.
module alu_seq
    import alu_pkg::*;
#(
    parameter  int WIDTH     = 18,
    parameter  int IMM_WIDTH = 6,
    localparam int SH_W      = $clog2(WIDTH)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [2:0]           op,
    input  logic                 use_imm,
    input  logic [WIDTH-1:0]     src1,
    input  logic [WIDTH-1:0]     src2,
    input  logic [IMM_WIDTH-1:0] imm,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WIDTH-1:0]     result,
    output logic                 flag_z,
    output logic                 flag_n,
    output logic                 flag_c,
    output logic                 flag_v,
    output logic                 busy
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    state_e             r_state, w_state_next;
    logic [2:0]         r_op;
    logic [WIDTH-1:0]   r_b;
    logic [2*WIDTH-1:0] r_acc, w_acc_next;
    logic [CNT_W-1:0]   r_cnt, w_cnt_next;
    logic               r_sh_big, w_sh_big_next;
    logic [WIDTH-1:0]   r_result, w_result_next;
    logic               r_z, r_n, r_c, r_v;
    logic               w_c_next, w_v_next, w_load;

    logic [WIDTH-1:0]   w_b;
    logic [SH_W-1:0]    w_amt;
    logic [CNT_W-1:0]   w_amt_ext;
    logic               w_accept;
    logic [WIDTH:0]     w_mul_sum;
    logic               w_shift_out;

    logic [WIDTH-1:0]   w_core_result;
    logic               w_core_z, w_core_n, w_core_c, w_core_v;

    assign w_b       = use_imm ? WIDTH'(sign_extend(64'(imm), IMM_WIDTH)) : src2;
    assign w_amt     = w_b[SH_W-1:0];
    assign w_amt_ext = CNT_W'(w_amt);
    assign in_ready  = (r_state == S_IDLE);
    assign w_accept  = in_valid && in_ready;
    assign out_valid = (r_state == S_DONE);
    assign busy      = (r_state == S_EXEC) || (r_state == S_DONE);
    assign result    = r_result;
    assign flag_z    = r_z;
    assign flag_n    = r_n;
    assign flag_c    = r_c;
    assign flag_v    = r_v;

    alu_comb_core #(.WIDTH(WIDTH)) u_core (
        .op     (op),
        .a      (src1),
        .b      (w_b),
        .result (w_core_result),
        .flag_z (w_core_z),
        .flag_n (w_core_n),
        .flag_c (w_core_c),
        .flag_v (w_core_v)
    );

    always_comb begin
        w_state_next  = r_state;
        w_acc_next    = r_acc;
        w_cnt_next    = r_cnt;
        w_sh_big_next = r_sh_big;
        w_load        = 1'b0;
        w_result_next = r_result;
        w_c_next      = r_c;
        w_v_next      = r_v;
        w_shift_out   = 1'b0;
        // Multiplier bit is r_acc[0]; partial product accumulates in the top half.
        w_mul_sum     = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_b} : '0);

        case (r_state)
            S_IDLE: begin
                if (in_valid) begin
                    case (op)
                        OP_MUL: begin
                            w_acc_next   = {{WIDTH{1'b0}}, src1};
                            w_cnt_next   = CNT_W'(WIDTH);
                            w_state_next = S_EXEC;
                        end
                        OP_SHL, OP_SHR: begin
                            if (w_amt == '0) begin
                                w_load        = 1'b1;
                                w_result_next = src1;
                                w_c_next      = 1'b0;
                                w_v_next      = 1'b0;
                                w_state_next  = S_DONE;
                            end else begin
                                // Oversized shifts run WIDTH steps; the carry is then masked.
                                w_sh_big_next = (w_amt_ext > CNT_W'(WIDTH));
                                w_cnt_next    = w_sh_big_next ? CNT_W'(WIDTH) : w_amt_ext;
                                w_acc_next    = {{WIDTH{1'b0}}, src1};
                                w_state_next  = S_EXEC;
                            end
                        end
                        default: begin
                            w_load        = 1'b1;
                            w_result_next = w_core_result;
                            w_c_next      = w_core_c;
                            w_v_next      = w_core_v;
                            w_state_next  = S_DONE;
                        end
                    endcase
                end
            end
            S_EXEC: begin
                w_cnt_next = r_cnt - 1'b1;
                case (r_op)
                    OP_SHL: begin
                        w_acc_next  = {{WIDTH{1'b0}}, r_acc[WIDTH-2:0], 1'b0};
                        w_shift_out = r_acc[WIDTH-1];
                    end
                    OP_SHR: begin
                        w_acc_next  = {{WIDTH{1'b0}}, 1'b0, r_acc[WIDTH-1:1]};
                        w_shift_out = r_acc[0];
                    end
                    default: w_acc_next = {w_mul_sum, r_acc[WIDTH-1:1]};
                endcase
                if (r_cnt == CNT_W'(1)) begin
                    w_load        = 1'b1;
                    w_result_next = w_acc_next[WIDTH-1:0];
                    w_c_next      = (r_op == OP_MUL) ? |w_acc_next[2*WIDTH-1:WIDTH]
                                                     : (w_shift_out & ~r_sh_big);
                    w_v_next      = 1'b0;
                    w_state_next  = S_DONE;
                end
            end
            S_DONE: begin
                if (out_ready) w_state_next = S_IDLE;
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_op     <= '0;
            r_b      <= '0;
            r_acc    <= '0;
            r_cnt    <= '0;
            r_sh_big <= 1'b0;
            r_result <= '0;
            r_z      <= 1'b0;
            r_n      <= 1'b0;
            r_c      <= 1'b0;
            r_v      <= 1'b0;
        end else begin
            r_state  <= w_state_next;
            r_acc    <= w_acc_next;
            r_cnt    <= w_cnt_next;
            r_sh_big <= w_sh_big_next;
            if (w_accept) begin
                r_op <= op;
                r_b  <= w_b;
            end
            if (w_load) begin
                r_result <= w_result_next;
                r_z      <= (w_result_next == '0);
                r_n      <= w_result_next[WIDTH-1];
                r_c      <= w_c_next;
                r_v      <= w_v_next;
            end
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// Directed and random transactions for alu_seq, checked against an
// arithmetic reference model of each opcode.
module tb_alu_seq;

    localparam int     W     = 18;
    localparam int     IW    = 6;
    localparam int     SW    = $clog2(W);
    localparam longint MASK  = (longint'(1) << W) - 1;
    localparam longint MAXS  = (longint'(1) << (W - 1)) - 1;
    localparam longint MINS  = -(longint'(1) << (W - 1));

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [2:0]    op = '0;
    logic          use_imm = 1'b0;
    logic [W-1:0]  src1 = '0;
    logic [W-1:0]  src2 = '0;
    logic [IW-1:0] imm = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [W-1:0]  result;
    logic          flag_z, flag_n, flag_c, flag_v, busy;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    alu_seq #(.WIDTH(W), .IMM_WIDTH(IW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .use_imm   (use_imm),
        .src1      (src1),
        .src2      (src2),
        .imm       (imm),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .flag_z    (flag_z),
        .flag_n    (flag_n),
        .flag_c    (flag_c),
        .flag_v    (flag_v),
        .busy      (busy)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    function automatic longint sext_imm(input longint v);
        return ((v >> (IW - 1)) & 1) ? ((v - (longint'(1) << IW)) & MASK) : v;
    endfunction

    function automatic longint to_signed(input longint v);
        return ((v >> (W - 1)) & 1) ? v - (longint'(1) << W) : v;
    endfunction

    function automatic void model(input int o, input longint a, input longint b,
                                  output longint res, output longint c,
                                  output longint v, output int lat);
        longint s;
        int     amt;
        amt = int'(b & ((1 << SW) - 1));
        c   = 0;
        v   = 0;
        lat = 1;
        res = 0;
        case (o)
            0: begin
                s   = a + b;
                res = s & MASK;
                c   = (s >> W) & 1;
                s   = to_signed(a) + to_signed(b);
                v   = (s > MAXS || s < MINS) ? 1 : 0;
            end
            1: res = a & b;
            2: res = ~(a & b) & MASK;
            3: res = ~(a | b) & MASK;
            4: begin
                s   = a + (~b & MASK) + 1;
                res = s & MASK;
                c   = (s >> W) & 1;
                s   = to_signed(a) - to_signed(b);
                v   = (s > MAXS || s < MINS) ? 1 : 0;
            end
            5: begin
                res = (a << amt) & MASK;
                c   = ((a << amt) >> W) & 1;
                lat = ((amt < W) ? amt : W) + 1;
            end
            6: begin
                res = a >> amt;
                c   = (amt == 0) ? 0 : (((a << 1) >> amt) & 1);
                lat = ((amt < W) ? amt : W) + 1;
            end
            default: begin
                s   = a * b;
                res = s & MASK;
                c   = ((s >> W) != 0) ? 1 : 0;
                lat = W + 1;
            end
        endcase
    endfunction

    task automatic run_op(input string tag, input int o, input bit ui,
                          input longint a, input longint s2, input longint im,
                          input int hold);
        longint b, eres, ec, ev;
        int     elat, edges;
        b = ui ? sext_imm(im & ((1 << IW) - 1)) : s2;
        model(o, a, b, eres, ec, ev, elat);

        edges = 0;
        while (!in_ready && edges < 50) begin
            @(posedge clk); #1; edges++;
        end
        chk({tag, ".in_ready"}, in_ready, 1);

        op = o[2:0]; use_imm = ui; src1 = a[W-1:0]; src2 = s2[W-1:0];
        imm = im[IW-1:0]; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        op = 3'($urandom); src1 = W'($urandom); src2 = W'($urandom);
        imm = IW'($urandom); use_imm = 1'($urandom);
        chk({tag, ".busy"}, busy, 1);

        edges = 1;
        while (!out_valid && edges < W + 10) begin
            @(posedge clk); #1; edges++;
        end
        chk({tag, ".latency"}, edges, elat);
        chk({tag, ".result"}, result, eres);
        chk({tag, ".z"}, flag_z, (eres == 0) ? 1 : 0);
        chk({tag, ".n"}, flag_n, (eres >> (W - 1)) & 1);
        chk({tag, ".c"}, flag_c, ec);
        chk({tag, ".v"}, flag_v, ev);

        for (int h = 0; h < hold; h++) begin
            @(posedge clk); #1;
            chk({tag, ".hold_valid"}, out_valid, 1);
            chk({tag, ".hold_result"}, result, eres);
            chk({tag, ".hold_ready"}, in_ready, 0);
        end

        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk({tag, ".drain_valid"}, out_valid, 0);
        chk({tag, ".drain_ready"}, in_ready, 1);
        $display("txn %s op=%0d a=0x%05h b=0x%05h result=0x%05h edges=%0d",
                 tag, o, a, b, result, edges);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("reset.in_ready", in_ready, 1);
        chk("reset.out_valid", out_valid, 0);
        chk("reset.result", result, 0);
        chk("reset.busy", busy, 0);
        chk("reset.flags", {flag_z, flag_n, flag_c, flag_v}, 0);
        rst_n = 1'b1;

        run_op("add",      0, 0, 'h01234, 'h05678, 0,    0);
        run_op("nand",     2, 0, 'h0ABCD, 'h0EF01, 0,    0);
        run_op("nor",      3, 0, 'h01111, 'h00000, 0,    0);
        run_op("add_imm",  0, 1, 'h07FFF, 0,       'h3F, 0);
        run_op("add_ovf",  0, 0, 'h1FFFF, 'h00001, 0,    0);
        run_op("and",      1, 0, 'h3C3C3, 'h0FF0F, 0,    0);
        run_op("sub",      4, 0, 'h00005, 'h00007, 0,    0);
        run_op("sub_ovf",  4, 0, 'h20000, 'h00001, 0,    0);
        run_op("shl17",    5, 0, 'h00001, 17,      0,    0);
        run_op("shr0",     6, 0, 'h2A5A5, 0,       0,    0);
        run_op("shl25",    5, 0, 'h00001, 25,      0,    0);
        run_op("shr_imm",  6, 1, 'h3FFFF, 0,       'h03, 0);
        run_op("mul",      7, 0, 'h00123, 'h00010, 0,    3);
        run_op("mul_big",  7, 0, 'h3FFFF, 'h3FFFF, 0,    0);

        for (int i = 0; i < 40; i++) begin
            run_op("rand", int'($urandom_range(0, 7)), 1'($urandom),
                   longint'($urandom) & MASK, longint'($urandom) & MASK,
                   longint'($urandom_range(0, 63)), int'($urandom_range(0, 2)));
        end

        // Reset in the middle of a multiply, with a request presented on the reset edge.
        op = 3'd7; use_imm = 1'b0; src1 = 'h00123; src2 = 'h00010; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        chk("rstmid.busy_before", busy, 1);
        rst_n = 1'b0; in_valid = 1'b1; op = 3'd0; src1 = 'h00001; src2 = 'h00001;
        @(posedge clk); #1;
        chk("rstmid.out_valid", out_valid, 0);
        chk("rstmid.result", result, 0);
        chk("rstmid.in_ready", in_ready, 1);
        chk("rstmid.flags", {flag_z, flag_n, flag_c, flag_v}, 0);
        rst_n = 1'b1; in_valid = 1'b0;
        @(posedge clk); #1;
        chk("rstmid.ignored_req", out_valid, 0);
        chk("rstmid.busy_after", busy, 0);
        run_op("post_rst_add", 0, 0, 'h00100, 'h00023, 0, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
